// File: rtl/alu_slice_serial_if.sv
// Handshake and data bundle for alu_slice_serial.
//   Input side : in_valid/in_ready handshake carrying a, b, s, m, cin_n.
//   Output side: out_valid/out_ready handshake carrying y, cout_n, zero.
// The master modport belongs to whoever supplies operands and takes results.
// The slave modport belongs to the ALU.
interface alu_slice_serial_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       s;
    logic             m;
    logic             cin_n;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             cout_n;
    logic             zero;

    modport master (
        output in_valid, a, b, s, m, cin_n, out_ready,
        input  in_ready, out_valid, y, cout_n, zero
    );

    modport slave (
        input  in_valid, a, b, s, m, cin_n, out_ready,
        output in_ready, out_valid, y, cout_n, zero
    );
endinterface

// File: rtl/alu_slice_serial.sv
// Bit-serial-by-slice '181-style ALU.
// One SLICE_W-bit slice is evaluated per clock, LSB first. The carry between
// slices lives in a register, so the chain of slices reproduces the full-width
// sum exactly. Carries on the bus are active-low.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - alu_slice_serial_if.slave (operand handshake in, result handshake out)
module alu_slice_serial #(
    parameter int WIDTH   = 16,
    parameter int SLICE_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_slice_serial_if.slave    bus
);
    localparam int N    = WIDTH / SLICE_W;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, b_q, y_q, y_new;
    logic [3:0]         s_q;
    logic               m_q;
    logic               carry_q;
    logic               cout_n_q;
    logic               zero_q;
    logic [IDXW-1:0]    idx_q;

    logic [SLICE_W-1:0] as, bs, xs, ys, fs, f_slice;
    logic [SLICE_W:0]   sum;
    logic               carry_next;
    logic               last;

    assign last = (idx_q == IDXW'(N - 1));

    // Slice evaluation for the current index.
    always_comb begin
        as = SLICE_W'(a_q >> (idx_q * SLICE_W));
        bs = SLICE_W'(b_q >> (idx_q * SLICE_W));
        xs = '0;
        ys = '0;
        fs = '0;
        case (s_q)
            4'h0: begin xs = as;        ys = '0;       fs = ~as;        end
            4'h1: begin xs = as | bs;   ys = '0;       fs = ~(as | bs); end
            4'h2: begin xs = as | ~bs;  ys = '0;       fs = ~as & bs;   end
            4'h3: begin xs = '0;        ys = '1;       fs = '0;         end
            4'h4: begin xs = as;        ys = as & ~bs; fs = ~(as & bs); end
            4'h5: begin xs = as | bs;   ys = as & ~bs; fs = ~bs;        end
            4'h6: begin xs = as;        ys = ~bs;      fs = as ^ bs;    end
            4'h7: begin xs = as & ~bs;  ys = '1;       fs = as & ~bs;   end
            4'h8: begin xs = as;        ys = as & bs;  fs = ~as | bs;   end
            4'h9: begin xs = as;        ys = bs;       fs = ~(as ^ bs); end
            4'hA: begin xs = as | ~bs;  ys = as & bs;  fs = bs;         end
            4'hB: begin xs = as & bs;   ys = '1;       fs = as & bs;    end
            4'hC: begin xs = as;        ys = as;       fs = '1;         end
            4'hD: begin xs = as | bs;   ys = as;       fs = as | ~bs;   end
            4'hE: begin xs = as | ~bs;  ys = as;       fs = as | bs;    end
            default: begin xs = as;     ys = '1;       fs = as;         end
        endcase
        sum        = {1'b0, xs} + {1'b0, ys} + {{SLICE_W{1'b0}}, carry_q};
        f_slice    = m_q ? fs : sum[SLICE_W-1:0];
        carry_next = m_q ? 1'b0 : sum[SLICE_W];
    end

    // Result with the current slice merged in; everything else passes through.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slice
            assign y_new[gi*SLICE_W +: SLICE_W] =
                (idx_q == IDXW'(gi)) ? f_slice : y_q[gi*SLICE_W +: SLICE_W];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = CALC;
            CALC:    if (last)         state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= '0;
            m_q      <= 1'b0;
            carry_q  <= 1'b0;
            y_q      <= '0;
            cout_n_q <= 1'b1;
            zero_q   <= 1'b0;
            idx_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        s_q     <= bus.s;
                        m_q     <= bus.m;
                        // Logic mode never propagates a carry.
                        carry_q <= bus.m ? 1'b0 : ~bus.cin_n;
                        idx_q   <= '0;
                    end
                end
                CALC: begin
                    y_q     <= y_new;
                    carry_q <= carry_next;
                    idx_q   <= last ? '0 : idx_q + IDXW'(1);
                    if (last) begin
                        cout_n_q <= ~carry_next;
                        zero_q   <= (y_new == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.y         = y_q;
    assign bus.cout_n    = cout_n_q;
    assign bus.zero      = zero_q;
endmodule
